mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage responder for the decode-side memory controls (MemWrite, MemRead, modeAddr) once they are piped to M.
- Converts byte/half/word, signed/unsigned loads and stores into word-aligned requests on a 32-bit data-memory bus with byte enables, using a valid/ready request and rvalid response.
- Returns sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- MemWriteM  in  1  store request
- MemReadM  in  1  load request
- modeAddrM  in  3  access mode: 001 word, 010 half, 011 byte, 100 unsigned half, 101 unsigned byte, 000 none
- AddrM  in  32  byte address (ALU result)
- WriteDataM  in  32  store data, right-aligned
- ReadDataM  out  32  extended load data
- StallM  out  1  hold the pipeline; all M inputs stay stable while high
- FaultM  out  1  one-cycle pulse on misaligned or invalid access
- mem_req  out  1  request valid
- mem_we  out  1  write
- mem_addr  out  32  word address (AddrM with [1:0] forced to 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, immediate): state IDLE. mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, ReadDataM=0, StallM=0, FaultM=0.
- Command decode:
  - Store: MemWriteM=1. Store has priority if MemReadM is also high.
  - Load: MemReadM=1 and MemWriteM=0.
  - MemReadM with mode 000 is a no-op: no access, no stall, no fault.
- Fault conditions:
  - Store with mode 000, 100, 101, 110 or 111.
  - Load with mode 110 or 111.
  - Half access with AddrM[0]=1.
  - Word access with AddrM[1:0]!=0.
  - On fault, registered FaultM=1 for exactly one cycle. No bus request, no stall.
- Byte enables and store lanes:
  - Byte: be = 0001 << AddrM[1:0]; wdata = {4{WriteDataM[7:0]}}.
  - Half: be = 0011 << AddrM[1:0]; wdata = {2{WriteDataM[15:0]}}.
  - Word: be = 1111; wdata = WriteDataM.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On a valid access: register addr, be, wdata, we, mode and AddrM[1:0], then go to REQ.
  - StallM is combinationally high in that same cycle.
- REQ:
  - mem_req=1, stable until mem_ready.
  - On mem_ready: store goes to DONE; load goes to RESP.
- RESP:
  - Wait for mem_rvalid. rvalid asserted in the same cycle as ready is not allowed; the responder gives rvalid at least one cycle after ready.
  - On rvalid: select lane by saved offset, sign- or zero-extend into ReadDataM, go to DONE.
- DONE:
  - StallM=0; ReadDataM valid this cycle and held until the next load completes.
  - Always returns to IDLE, so the same instruction is not re-issued.
- StallM is high in IDLE-with-valid-access, REQ and RESP.
- Minimum latency:
  - Store: 2 stall cycles with ready immediate.
  - Load: 3 stall cycles with ready and then rvalid on the next cycle.
- mem_rvalid in IDLE, REQ or DONE is ignored. This covers a stale response after reset.
- Reset mid-operation drops mem_req at once. The pipeline must reissue.

Decomposition:
- Shared package mem_pkg:
  - mode enum (MODE_NONE, MODE_W, MODE_H, MODE_B, MODE_HU, MODE_BU).
  - State typedef.
  - Byte-enable width constant.
- Sub-module load_extend (combinational): rdata, offset, mode -> extended 32-bit value. Reusable by a future cache.

Test Plan:
- sb: AddrM=0x1002, WriteDataM=0x000000AB, ready immediate -> mem_addr=0x1000, be=0100, wdata=0xABABABAB, mem_we=1. StallM high 2 cycles, FaultM=0.
- lb then lbu: AddrM=0x2003, rdata=0x80FF1234 -> ReadDataM=0xFFFFFF80 for lb, 0x00000080 for lbu.
- lh/lhu: AddrM=0x2002, rdata=0x8001_0000 -> 0xFFFF8001 / 0x00008001. With ready held low 3 cycles, mem_req and mem_addr stay stable and StallM lasts 6 cycles.
- Misaligned: lw at 0x2001 and lh at 0x2003 -> FaultM one cycle each, no mem_req, StallM=0.
- No-op: MemReadM=1 with mode 000 -> no mem_req, no stall, no fault. Store with mode 101 -> FaultM.
- Reset: rst pulse while in RESP -> mem_req and StallM drop asynchronously. A late rvalid afterwards leaves ReadDataM=0. The next lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access unit: access modes, FSM state encoding
// and the byte-enable width.
package mem_pkg;
  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    MODE_NONE = 3'b000,
    MODE_W    = 3'b001,
    MODE_H    = 3'b010,
    MODE_B    = 3'b011,
    MODE_HU   = 3'b100,
    MODE_BU   = 3'b101
  } mode_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_DONE = 2'd3;
endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational so it can sit behind any word-wide read path.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mode_t       mode,
  output logic [31:0] ext
);
  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (mode)
      MODE_B:  ext = {{24{sh[7]}}, sh[7:0]};
      MODE_BU: ext = {24'h0, sh[7:0]};
      MODE_H:  ext = {{16{sh[15]}}, sh[15:0]};
      MODE_HU: ext = {16'h0, sh[15:0]};
      default: ext = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage responder: turns byte/half/word loads and stores into word-aligned
// bus requests with byte enables, stalls while outstanding, returns extended data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [2:0]            modeAddrM,
  input  logic [DATA_WIDTH-1:0] AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  FaultM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [BE_W-1:0]       mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  mode_t                 mode_q, mode_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic                  is_st, is_ld, is_half, is_word;
  logic                  bad_mode, misalign, access, fault, go;
  logic [BE_W-1:0]       be_n;
  logic [DATA_WIDTH-1:0] wd_n, ext;

  // Store wins over load when both strobes are up.
  always_comb begin
    is_st    = MemWriteM;
    is_ld    = MemReadM & ~MemWriteM;
    is_half  = (modeAddrM == MODE_H) || (modeAddrM == MODE_HU);
    is_word  = (modeAddrM == MODE_W);
    bad_mode = is_st ? !((modeAddrM == MODE_W) || (modeAddrM == MODE_H) || (modeAddrM == MODE_B))
                     : (modeAddrM[2:1] == 2'b11);
    misalign = (is_half & AddrM[0]) | (is_word & (AddrM[1:0] != 2'b00));
    access   = is_st | (is_ld & (modeAddrM != MODE_NONE));
    fault    = access & (bad_mode | misalign);
    go       = access & ~fault;
  end

  always_comb begin
    case (modeAddrM)
      MODE_B, MODE_BU: begin
        be_n = 4'b0001 << AddrM[1:0];
        wd_n = {4{WriteDataM[7:0]}};
      end
      MODE_H, MODE_HU: begin
        be_n = 4'b0011 << AddrM[1:0];
        wd_n = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = WriteDataM;
      end
    endcase
  end

  load_extend u_ext (
    .rdata  (mem_rdata),
    .offset (off_q),
    .mode   (mode_q),
    .ext    (ext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mode_d  = mode_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fault_d = fault;
        if (go) begin
          state_d = ST_REQ;
          addr_d  = {AddrM[DATA_WIDTH-1:2], 2'b00};
          be_d    = be_n;
          wdata_d = wd_n;
          we_d    = is_st;
          mode_d  = mode_t'(modeAddrM);
          off_d   = AddrM[1:0];
        end
      end
      ST_REQ:  if (mem_ready) state_d = we_q ? ST_DONE : ST_RESP;
      ST_RESP: begin
        if (mem_rvalid) begin
          rdata_d = ext;
          state_d = ST_DONE;
        end
      end
      // DONE never looks at the inputs, so the held instruction is not reissued.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mode_q  <= MODE_NONE;
      off_q   <= 2'b00;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_req ? be_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign FaultM    = fault_q;
  assign StallM    = ((state_q == ST_IDLE) & go & ~rst) |
                     (state_q == ST_REQ) | (state_q == ST_RESP);
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes hand-computed expectations,
// a negedge monitor pops and compares as the DUT presents requests, stalls and faults.
module tb_mem_access_unit;
  localparam int K_ST = 0, K_LD = 1, K_FAULT = 2, K_ABORT = 3, K_NOP = 4;

  typedef struct {
    logic        we, rd;
    logic [2:0]  mode;
    logic [31:0] addr, wdata, rdata;
    int          rwait, kind;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    int          estall;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        MemWriteM = 0, MemReadM = 0;
  logic [2:0]  modeAddrM = 0;
  logic [31:0] AddrM = 0, WriteDataM = 0, ReadDataM;
  logic        StallM, FaultM, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  int   tests = 0, fails = 0, stall_cnt = 0;
  vec_t sbq[$];
  vec_t vecs[$];

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .modeAddrM(modeAddrM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic rd, input logic [2:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int rwait, input int kind,
                              input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd,
                              input int estall);
    vec_t v;
    v.we = we; v.rd = rd; v.mode = mode; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rwait = rwait; v.kind = kind; v.eaddr = eaddr; v.ebe = ebe;
    v.ewd = ewd; v.erd = erd; v.estall = estall;
    return v;
  endfunction

  task automatic clear_in();
    MemWriteM = 0; MemReadM = 0; modeAddrM = 0; AddrM = 0; WriteDataM = 0;
  endtask

  task automatic run(input vec_t v);
    @(posedge clk); #1;
    MemWriteM = v.we; MemReadM = v.rd; modeAddrM = v.mode; AddrM = v.addr; WriteDataM = v.wdata;
    if (v.kind == K_NOP) begin
      #1;
      chk("nop_stall", {31'h0, StallM}, 32'h0);
      chk("nop_req", {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      chk("nop_fault", {31'h0, FaultM}, 32'h0);
    end else begin
      sbq.push_back(v);
      if (v.kind == K_FAULT) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
        repeat (v.rwait) begin @(posedge clk); #1; end
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        if (v.kind == K_LD) begin
          mem_rvalid = 1; mem_rdata = v.rdata;
          @(posedge clk); #1;
          mem_rvalid = 0;
        end
      end
    end
    clear_in();
  endtask

  // Monitor: requests checked every cycle they are up, stalls counted, faults popped.
  always @(negedge clk) begin
    vec_t v;
    if (FaultM) begin
      if (sbq.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
      else begin
        v = sbq.pop_front();
        chk("fault_kind", {31'h0, v.kind == K_FAULT}, 32'd1);
        chk("fault_noreq", {31'h0, mem_req}, 32'h0);
        chk("fault_nostall", {31'h0, StallM}, 32'h0);
      end
    end
    if (mem_req) begin
      if (sbq.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        v = sbq[0];
        chk("req_addr", mem_addr, v.eaddr);
        chk("req_be", {28'h0, mem_be}, {28'h0, v.ebe});
        chk("req_we", {31'h0, mem_we}, {31'h0, v.kind == K_ST});
        if (v.kind == K_ST) chk("req_wdata", mem_wdata, v.ewd);
      end
    end
    if (StallM) stall_cnt++;
    else if (stall_cnt > 0) begin
      if (sbq.size() == 0) chk("unexpected_stall", 32'(stall_cnt), 32'd0);
      else begin
        v = sbq.pop_front();
        chk("stall_cycles", 32'(stall_cnt), 32'(v.estall));
        if (v.kind == K_LD || v.kind == K_ABORT) chk("read_data", ReadDataM, v.erd);
      end
      stall_cnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(1,0,3'b011,32'h1002,32'h000000AB,0,0,K_ST,32'h1000,4'b0100,32'hABABABAB,0,2));
    vecs.push_back(mk(1,0,3'b010,32'h1002,32'h00001234,0,0,K_ST,32'h1000,4'b1100,32'h12341234,0,2));
    vecs.push_back(mk(1,0,3'b001,32'h1004,32'hCAFEF00D,0,1,K_ST,32'h1004,4'b1111,32'hCAFEF00D,0,3));
    vecs.push_back(mk(0,1,3'b011,32'h2003,0,32'h80FF1234,0,K_LD,32'h2000,4'b1000,0,32'hFFFFFF80,3));
    vecs.push_back(mk(0,1,3'b101,32'h2003,0,32'h80FF1234,0,K_LD,32'h2000,4'b1000,0,32'h00000080,3));
    vecs.push_back(mk(0,1,3'b010,32'h2002,0,32'h80010000,3,K_LD,32'h2000,4'b1100,0,32'hFFFF8001,6));
    vecs.push_back(mk(0,1,3'b100,32'h2002,0,32'h80010000,0,K_LD,32'h2000,4'b1100,0,32'h00008001,3));
    vecs.push_back(mk(0,1,3'b001,32'h2000,0,32'h80FF1234,0,K_LD,32'h2000,4'b1111,0,32'h80FF1234,3));
    vecs.push_back(mk(0,1,3'b011,32'h2001,0,32'h80FF1234,0,K_LD,32'h2000,4'b0010,0,32'h00000012,3));
    vecs.push_back(mk(0,1,3'b001,32'h2001,0,0,0,K_FAULT,0,0,0,0,0));
    vecs.push_back(mk(0,1,3'b010,32'h2003,0,0,0,K_FAULT,0,0,0,0,0));
    vecs.push_back(mk(1,0,3'b101,32'h1000,32'h11,0,0,K_FAULT,0,0,0,0,0));
    vecs.push_back(mk(0,1,3'b110,32'h2000,0,0,0,K_FAULT,0,0,0,0,0));
    vecs.push_back(mk(0,1,3'b000,32'h2000,0,0,0,K_NOP,0,0,0,0,0));
    vecs.push_back(mk(1,1,3'b011,32'h1001,32'h0000005A,0,0,K_ST,32'h1000,4'b0010,32'h5A5A5A5A,0,2));

    @(posedge clk); #2;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_fault", {31'h0, FaultM}, 32'h0);
    rst = 0;

    foreach (vecs[i]) run(vecs[i]);

    // Reset while waiting for the load response.
    @(posedge clk); #1;
    MemReadM = 1; modeAddrM = 3'b001; AddrM = 32'h3000;
    sbq.push_back(mk(0,1,3'b001,32'h3000,0,0,0,K_ABORT,32'h3000,4'b1111,0,32'h0,3));
    @(posedge clk); #1 mem_ready = 1;
    @(posedge clk); #1 mem_ready = 0;
    @(negedge clk); #2;
    rst = 1; clear_in();
    #1;
    chk("arst_stall", {31'h0, StallM}, 32'h0);
    chk("arst_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1 mem_rvalid = 0;
    chk("late_rvalid_ignored", ReadDataM, 32'h0);
    run(mk(0,1,3'b001,32'h3004,0,32'h12345678,0,K_LD,32'h3004,4'b1111,0,32'h12345678,3));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
